// File: rtl/usr_shift_sequencer.sv
// Sequencer driving a universal shift register for TX (parallel-to-serial) and
// RX (serial-to-parallel) jobs, arbitrating between the two requesters.
module usr_shift_sequencer #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_dir,
  output logic             tx_done,
  input  logic             rx_req,
  input  logic             rx_dir,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  input  logic             pause,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_pi,
  input  logic [WIDTH-1:0] sr_po,
  output logic             bit_act,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RX_HOLD} state_t;
  typedef enum logic {JOB_TX, JOB_RX} job_t;

  localparam logic [1:0]       SEL_HOLD  = 2'b00;
  localparam logic [1:0]       SEL_RIGHT = 2'b01;
  localparam logic [1:0]       SEL_LEFT  = 2'b10;
  localparam logic [1:0]       SEL_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  job_t             job;
  job_t             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tx_buf;
  logic             dir;
  logic             grant_tx;
  logic             grant_rx;
  logic             shift_en;

  // Round-robin grant: TX wins contention only if RX was served last.
  always_comb begin
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    if (state == IDLE) begin
      grant_tx = tx_valid & (~rx_req | (last_grant == JOB_RX));
      grant_rx = rx_req & ~grant_tx;
    end
  end

  assign shift_en = (state == SHIFT) && !pause;
  assign tx_ready = grant_tx;
  assign rx_data  = sr_po;
  assign bit_act  = shift_en;
  assign sr_pi    = (state == LOAD) ? tx_buf : '0;

  // Shift-register control decoded from the current state.
  always_comb begin
    sr_sel = SEL_HOLD;
    case (state)
      LOAD:    sr_sel = SEL_LOAD;
      SHIFT:   if (!pause) sr_sel = dir ? SEL_LEFT : SEL_RIGHT;
      default: sr_sel = SEL_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_buf     <= '0;
      job        <= JOB_TX;
      dir        <= 1'b0;
      last_grant <= JOB_RX;
      tx_done    <= 1'b0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_tx) begin
            tx_buf     <= tx_data;
            dir        <= tx_dir;
            job        <= JOB_TX;
            last_grant <= JOB_TX;
            busy       <= 1'b1;
            state      <= LOAD;
          end else if (grant_rx) begin
            dir        <= rx_dir;
            job        <= JOB_RX;
            last_grant <= JOB_RX;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (shift_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              if (job == JOB_TX) begin
                tx_done <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                rx_valid <= 1'b1;
                state    <= RX_HOLD;
              end
            end
          end
        end
        RX_HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a behavioural shift-register model.
module tb_usr_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_ready, tx_dir, tx_done;
  logic [4:0] tx_data;
  logic       rx_req, rx_dir, rx_valid, rx_ready;
  logic [4:0] rx_data;
  logic       pause;
  logic [1:0] sr_sel;
  logic [4:0] sr_pi, sr_po;
  logic       bit_act, busy;
  logic       si;
  logic [4:0] mq;
  logic       model_dir;

  int errors = 0;
  int checks = 0;

  usr_shift_sequencer #(.WIDTH(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_dir(tx_dir),
    .tx_done(tx_done),
    .rx_req(rx_req), .rx_dir(rx_dir), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data),
    .pause(pause), .sr_sel(sr_sel), .sr_pi(sr_pi), .sr_po(sr_po),
    .bit_act(bit_act), .busy(busy)
  );

  always #5 clk = ~clk;

  // Universal shift register: hold / right (si into MSB) / left (si into LSB) / load.
  always_ff @(posedge clk) begin
    case (sr_sel)
      2'b11:   mq <= sr_pi;
      2'b01:   mq <= {si, mq[4:1]};
      2'b10:   mq <= {mq[3:0], si};
      default: mq <= mq;
    endcase
  end
  assign sr_po = mq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One TX job; exp_bits[i] is the i-th serial bit, exp_len counts LOAD..last shift.
  task automatic run_tx(input string tag, input logic [4:0] data, input logic d,
                        input int p_start, input int p_len,
                        input logic [4:0] exp_bits, input int exp_len);
    logic [4:0] got;
    int         nb;
    int         len;
    logic       done;
    got  = '0;
    nb   = 0;
    len  = 1;
    done = 1'b0;
    model_dir = d;
    tx_valid = 1'b1; tx_data = data; tx_dir = d;
    #1;
    check({tag, " ready"}, 32'(tx_ready), 32'd1);
    check({tag, " idle_sel"}, 32'(sr_sel), 32'd0);
    tick();
    tx_valid = 1'b0; tx_data = ~data; tx_dir = ~d;
    #1;
    check({tag, " load_sel"}, 32'(sr_sel), 32'd3);
    check({tag, " load_pi"}, 32'(sr_pi), 32'(data));
    check({tag, " load_ready"}, 32'(tx_ready), 32'd0);
    check({tag, " load_busy"}, 32'(busy), 32'd1);
    for (int c = 0; c < 40; c++) begin
      tick();
      pause = (c >= p_start) && (c < p_start + p_len);
      #1;
      if (tx_done) begin
        done = 1'b1;
        break;
      end
      len++;
      if (pause) begin
        check({tag, " pause_sel"}, 32'(sr_sel), 32'd0);
        check({tag, " pause_act"}, 32'(bit_act), 32'd0);
      end else begin
        check({tag, " shift_sel"}, 32'(sr_sel), d ? 32'd2 : 32'd1);
        check({tag, " shift_act"}, 32'(bit_act), 32'd1);
      end
      if (bit_act && nb < 5) begin
        got[nb] = d ? mq[4] : mq[0];
        nb++;
      end
    end
    pause = 1'b0;
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " len"}, 32'(len), 32'(exp_len));
    check({tag, " bits"}, 32'(got), 32'(exp_bits));
    check({tag, " nbits"}, 32'(nb), 32'd5);
    check({tag, " end_busy"}, 32'(busy), 32'd0);
    check({tag, " end_sel"}, 32'(sr_sel), 32'd0);
    tick();
    #1;
    check({tag, " done_pulse"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    logic [4:0] rx_pat;
    logic [1:0] gr [4];
    int         ng;
    rst = 1'b1;
    tx_valid = 1'b0; tx_data = '0; tx_dir = 1'b0;
    rx_req = 1'b0; rx_dir = 1'b0; rx_ready = 1'b0;
    pause = 1'b0; si = 1'b0; model_dir = 1'b0;
    #3;
    check("rst sel", 32'(sr_sel), 32'd0);
    check("rst pi", 32'(sr_pi), 32'd0);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst bit_act", 32'(bit_act), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tx_done", 32'(tx_done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // TX right, LSB first.
    run_tx("txr", 5'b10110, 1'b0, 0, 0, 5'b10110, 6);

    // RX left: si = 1,0,0,1,1 gives 10011.
    rx_pat = 5'b11001;
    rx_req = 1'b1; rx_dir = 1'b1;
    #1;
    check("rx grant_tx_ready", 32'(tx_ready), 32'd0);
    tick();
    rx_req = 1'b0; rx_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      si = rx_pat[i];
      #1;
      check("rx sel", 32'(sr_sel), 32'd2);
      check("rx act", 32'(bit_act), 32'd1);
      check("rx valid_early", 32'(rx_valid), 32'd0);
      tick();
    end
    si = 1'b0;
    #1;
    check("rx valid", 32'(rx_valid), 32'd1);
    check("rx data", 32'(rx_data), 32'h13);
    check("rx hold_sel", 32'(sr_sel), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rx stall_valid", 32'(rx_valid), 32'd1);
      check("rx stall_data", 32'(rx_data), 32'h13);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    #1;
    check("rx released_valid", 32'(rx_valid), 32'd0);
    check("rx released_busy", 32'(busy), 32'd0);

    // Contention: both requesters held high.
    tx_valid = 1'b1; tx_data = 5'b00111; tx_dir = 1'b0;
    rx_req = 1'b1; rx_dir = 1'b0; rx_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      #1;
      if (!busy) begin
        gr[ng] = tx_ready ? 2'd1 : 2'd2;
        ng++;
      end
      tick();
    end
    tx_valid = 1'b0; rx_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      tick();
    end
    rx_ready = 1'b0;
    check("arb count", 32'(ng), 32'd4);
    check("arb drain", 32'(busy), 32'd0);
    if (ng == 4) begin
      check("arb g0", 32'(gr[0]), 32'd1);
      check("arb g1", 32'(gr[1]), 32'd2);
      check("arb g2", 32'(gr[2]), 32'd1);
      check("arb g3", 32'(gr[3]), 32'd2);
    end
    tick();

    // Pause for two cycles after the 2nd shift, MSB first.
    run_tx("pause", 5'b01101, 1'b1, 2, 2, 5'b10110, 8);

    // Async reset with cnt = 2.
    tx_valid = 1'b1; tx_data = 5'b11001; tx_dir = 1'b0;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    tick();
    check("arst pre_act", 32'(bit_act), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst sel", 32'(sr_sel), 32'd0);
    check("arst act", 32'(bit_act), 32'd0);
    check("arst done", 32'(tx_done), 32'd0);
    tick();
    rst = 1'b0;
    check("arst no_done", 32'(tx_done), 32'd0);
    tick();
    run_tx("post", 5'b11001, 1'b0, 0, 0, 5'b11001, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
